// File: rtl/aes_pkg.sv
// Shared constants and serializer state type for the inverse-AES output path.
package aes_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int AES_BYTES       = 16;
  localparam int INV_AES_LATENCY = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/blk_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rd_data whenever count is nonzero.
module blk_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wr_fire, rd_fire;

  assign wr_fire = wr_en && (count_reg != CNT_W'(DEPTH));
  assign rd_fire = rd_en && (count_reg != '0);

  // Pointers wrap at DEPTH, which need not be a power of two.
  assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
  assign rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

  always_comb begin
    count_next = count_reg;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_next;
      if (rd_fire) rd_ptr_reg <= rd_ptr_next;
      count_reg <= count_next;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/inv_aes_out_serializer.sv
// Credit-tracks blocks through a fixed-latency decryptor, buffers the plaintext
// and streams each 128-bit block out MSB byte first.
module inv_aes_out_serializer
  import aes_pkg::*;
#(
  parameter int LATENCY = INV_AES_LATENCY,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_valid_in,
  output logic                 blk_ready_out,
  input  logic [AES_BLK_W-1:0] pt_in,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = CNT_W + 1;

  logic [LATENCY-1:0]   tag_reg, tag_next;
  logic [CNT_W-1:0]     inflight_reg, inflight_next;
  logic                 overflow_reg;
  logic                 launch, tag_out;
  logic [OUT_W-1:0]     outstanding;

  logic [AES_BLK_W-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 pop;

  ser_state_t           state_reg, state_next;
  logic [AES_BLK_W-1:0] shift_reg, shift_next;
  logic [3:0]           idx_reg, idx_next;
  logic                 handshake;

  assign launch  = blk_valid_in && blk_ready_out;
  assign tag_out = tag_reg[LATENCY-1];
  // Casting drops the oldest tag, which keeps this legal for LATENCY == 1.
  assign tag_next = LATENCY'({tag_reg, launch});

  always_comb begin
    inflight_next = inflight_reg;
    case ({launch, tag_out})
      2'b10:   inflight_next = inflight_reg + CNT_W'(1);
      2'b01:   inflight_next = inflight_reg - CNT_W'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // Every block the upstream may launch already owns a FIFO slot or the serializer.
  assign outstanding   = OUT_W'(inflight_reg) + OUT_W'(fifo_count)
                       + OUT_W'(state_reg == SHIFT);
  assign blk_ready_out = (outstanding < OUT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_reg      <= '0;
      inflight_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      tag_reg      <= tag_next;
      inflight_reg <= inflight_next;
      if (blk_valid_in && !blk_ready_out) overflow_reg <= 1'b1;
    end
  end

  blk_fifo #(
    .WIDTH (AES_BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tag_out),
    .wr_data (pt_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign handshake = (state_reg == SHIFT) && byte_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          idx_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (handshake) begin
          if (idx_reg == 4'(AES_BYTES - 1)) begin
            idx_next = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_head;
            end else begin
              // Shifting out the last byte leaves zero on byte_out while idle.
              shift_next = {shift_reg[AES_BLK_W-9:0], 8'h00};
              state_next = IDLE;
            end
          end else begin
            shift_next = {shift_reg[AES_BLK_W-9:0], 8'h00};
            idx_next   = idx_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
    end
  end

  assign byte_out   = shift_reg[AES_BLK_W-1 -: 8];
  assign byte_valid = (state_reg == SHIFT);
  assign byte_last  = (state_reg == SHIFT) && (idx_reg == 4'(AES_BYTES - 1));
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_inv_aes_out_serializer.sv
// Directed and randomized checks of inv_aes_out_serializer against a block/byte queue model.
module tb_inv_aes_out_serializer;

  localparam int LATENCY = 10;
  localparam int DEPTH   = 4;
  localparam logic [127:0] FIXED_PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid_in;
  logic         blk_ready_out;
  logic [127:0] pt_in;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_last;
  logic         overflow;

  inv_aes_out_serializer #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .blk_valid_in  (blk_valid_in),
    .blk_ready_out (blk_ready_out),
    .pt_in         (pt_in),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_last     (byte_last),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: expected byte stream, scheduled plaintext, credit count.
  logic [7:0]   exp_bytes [$];
  int           due_q [$];
  logic [127:0] data_q [$];
  int           outstanding;
  int           exp_pos;
  logic         ovf_exp;
  int           cyc;
  int           total_hs;
  int           n_cmp;
  int           n_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: called at a negedge, drives inputs, checks outputs, advances to next negedge.
  task automatic step(input logic v, input logic r, input logic [127:0] d);
    logic launch;
    logic hs;
    logic rel;
    blk_valid_in = v;
    byte_ready   = r;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      pt_in = data_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      pt_in = rand_blk();
    end
    check("ready", blk_ready_out, outstanding < DEPTH);
    check("overflow", overflow, ovf_exp);
    check("no_spurious", byte_valid && (exp_bytes.size() == 0), 1'b0);
    if (byte_valid && exp_bytes.size() > 0) check("byte", byte_out, exp_bytes[0]);
    check("last", byte_last, byte_valid && (exp_pos == 15));
    hs  = byte_valid && r && (exp_bytes.size() > 0);
    rel = 1'b0;
    if (hs) begin
      void'(exp_bytes.pop_front());
      total_hs++;
      exp_pos++;
      if (exp_pos == 16) begin
        exp_pos = 0;
        rel     = 1'b1;
      end
    end
    launch = v && blk_ready_out;
    if (v && !blk_ready_out) ovf_exp = 1'b1;
    if (launch) begin
      for (int i = 0; i < 16; i++) exp_bytes.push_back(d[127 - 8*i -: 8]);
      due_q.push_back(cyc + LATENCY);
      data_q.push_back(d);
    end
    @(posedge clk);
    cyc++;
    outstanding = outstanding + int'(launch) - int'(rel);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    blk_valid_in = 1'b0;
    byte_ready   = 1'b0;
    pt_in        = rand_blk();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_bytes.delete();
    due_q.delete();
    data_q.delete();
    outstanding = 0;
    exp_pos     = 0;
    ovf_exp     = 1'b0;
    check("rst_valid", byte_valid, 1'b0);
    check("rst_ready", blk_ready_out, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    check("rst_last", byte_last, 1'b0);
    check("rst_byte", byte_out, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_bytes.size() > 0 || due_q.size() > 0) && guard < 2000) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    check("drain_done", exp_bytes.size(), 0);
  endtask

  initial begin
    int e0;
    int guard;
    int start_hs;
    n_cmp = 0; n_err = 0; cyc = 0; total_hs = 0;
    outstanding = 0; exp_pos = 0; ovf_exp = 1'b0;
    rst_n = 1'b0; blk_valid_in = 1'b0; byte_ready = 1'b0; pt_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single block: first byte L+1 edges after launch, 16 contiguous bytes.
    e0 = cyc;
    step(1'b1, 1'b1, FIXED_PT);
    guard = 0;
    while (!byte_valid && guard < 40) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    check("first_latency", (cyc - 1) - e0, LATENCY + 1);
    for (int i = 0; i < 16; i++) begin
      check("contig_single", byte_valid, 1'b1);
      step(1'b0, 1'b1, '0);
    end
    check("idle_after_single", byte_valid, 1'b0);

    // Back-to-back: four launches, 64 bytes with no bubble.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rand_blk());
    check("credit_exhausted", blk_ready_out, 1'b0);
    guard = 0;
    while (!byte_valid && guard < 40) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    for (int i = 0; i < 64; i++) begin
      check("contig_b2b", byte_valid, 1'b1);
      step(1'b0, 1'b1, '0);
    end
    drain();

    // Backpressure: hold byte_ready low for 40 cycles with four blocks launched.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_blk());
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0);
    check("bp_fifo_count", dut.fifo_count, 3);
    check("bp_holding", byte_valid, 1'b1);
    check("bp_ready_low", blk_ready_out, 1'b0);
    drain();

    // Illegal launch while out of credit: sticky overflow, no extra block.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_blk());
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_blk());
    drain();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    check("ovf_sticky", overflow, 1'b1);
    do_reset();

    // Reset mid-block with two blocks in flight.
    step(1'b1, 1'b1, rand_blk());
    step(1'b1, 1'b1, rand_blk());
    start_hs = total_hs;
    guard = 0;
    while (total_hs - start_hs < 5 && guard < 60) begin
      step(1'b0, 1'b1, '0);
      guard++;
    end
    check("pre_reset_bytes", total_hs - start_hs, 5);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, '0);

    // Randomized launches and backpressure with a well-behaved upstream.
    for (int i = 0; i < 10000; i++) begin
      step(blk_ready_out && ($urandom_range(0, 2) != 0),
           $urandom_range(0, 3) != 0, rand_blk());
    end
    drain();
    check("rand_no_overflow", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
